aes_mm_encryptor: RTL and testbench



---
 rtl/aes_mm_encryptor_if.sv | 38 +++
 rtl/aes_mm_encryptor.sv | 222 ++++++++++++++++++++++
 tb/tb_aes_mm_encryptor.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_mm_encryptor_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_mm_encryptor_if
// Brief    : Avalon-MM register slave and byte-wide read master bundle.
// Revision : 1.0
// ============================================================================
interface aes_mm_encryptor_if;
    logic        slave_waitrequest;
    logic        slave_read;
    logic        slave_write;
    logic [3:0]  slave_address;
    logic [31:0] slave_readdata;
    logic [31:0] slave_writedata;
    logic        master_waitrequest;
    logic        master_read;
    logic        master_write;
    logic        master_readdatavalid;
    logic [31:0] master_address;
    logic [7:0]  master_readdata;
    logic [7:0]  master_writedata;

    // Engine side of both buses
    modport slave (
        output slave_waitrequest, slave_readdata,
        input  slave_read, slave_write, slave_address, slave_writedata,
        input  master_waitrequest, master_readdatavalid, master_readdata,
        output master_read, master_write, master_address, master_writedata
    );

    // Host and memory side of both buses
    modport master (
        input  slave_waitrequest, slave_readdata,
        output slave_read, slave_write, slave_address, slave_writedata,
        output master_waitrequest, master_readdatavalid, master_readdata,
        input  master_read, master_write, master_address, master_writedata
    );
endinterface
`default_nettype wire

// File: rtl/aes_mm_encryptor.sv
`default_nettype none
// ============================================================================
// Module   : aes_mm_encryptor
// Brief    : Fetches a 288-byte S-box/key/plaintext image and runs AES-128.
// Revision : 1.0
// ============================================================================
module aes_mm_encryptor (
    input  logic                clk,
    input  logic                rst_n,
    aes_mm_encryptor_if.slave   bus,
    output logic                done
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_KEYROUND = 3'd2,
        S_ROUND    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [8:0] C_LAST_BYTE = 9'd287;
    localparam logic [3:0] C_LAST_ROUND = 4'd10;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_busy;
    logic        w_start;
    logic        w_byte_in;
    logic        w_accept;

    logic [31:0] r_word2;
    logic [31:0] r_ct [0:3];
    logic        r_done;
    logic        r_master_read;
    logic [8:0]  mem_i;
    logic [3:0]  r_round;

    logic [7:0]  sbox  [0:255];
    logic [7:0]  key   [0:15];
    logic [7:0]  block [0:15];
    logic [7:0]  r_st  [0:15];
    logic [7:0]  r_rk  [0:15];

    logic [7:0]  w_sub      [0:15];
    logic [7:0]  w_shift    [0:15];
    logic [7:0]  w_mix      [0:15];
    logic [7:0]  w_next_rk  [0:15];
    logic [7:0]  w_next_st  [0:15];
    logic [7:0]  w_rcon;
    logic [31:0] w_temp;
    logic [31:0] w_kw0, w_kw1, w_kw2, w_kw3;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign w_start   = bus.slave_write && (bus.slave_address == 4'd0) && bus.slave_writedata[0]
                       && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_byte_in = (r_state == S_FETCH) && bus.master_readdatavalid;
    assign w_accept  = r_master_read && !bus.master_waitrequest;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_busy = 1'b1;
                if (w_byte_in && (mem_i == C_LAST_BYTE)) w_next_state = S_KEYROUND;
            end
            S_KEYROUND: begin
                w_busy       = 1'b1;
                w_next_state = S_ROUND;
            end
            S_ROUND: begin
                w_busy = 1'b1;
                if (r_round == C_LAST_ROUND) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (w_start) w_next_state = S_FETCH;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // One read in flight: a returned byte re-arms the request for the next index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word2       <= '0;
            r_done        <= 1'b0;
            r_master_read <= 1'b0;
            mem_i         <= '0;
            r_round       <= '0;
            for (int i = 0; i < 4; i++) r_ct[i] <= '0;
        end else begin
            if (bus.slave_write && (bus.slave_address == 4'd2)) r_word2 <= bus.slave_writedata;
            if (w_start) begin
                mem_i         <= '0;
                r_done        <= 1'b0;
                r_master_read <= 1'b1;
            end else if (r_state == S_FETCH) begin
                if (w_byte_in) begin
                    if (mem_i != C_LAST_BYTE) begin
                        mem_i         <= mem_i + 9'd1;
                        r_master_read <= 1'b1;
                    end else begin
                        r_master_read <= 1'b0;
                    end
                end else if (w_accept) begin
                    r_master_read <= 1'b0;
                end
            end
            if (r_state == S_KEYROUND) r_round <= 4'd1;
            if (r_state == S_ROUND) begin
                r_round <= r_round + 4'd1;
                if (r_round == C_LAST_ROUND) begin
                    r_done <= 1'b1;
                    for (int c = 0; c < 4; c++)
                        r_ct[c] <= {w_next_st[4*c], w_next_st[4*c+1], w_next_st[4*c+2], w_next_st[4*c+3]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_byte_in) begin
            if (mem_i < 9'd256)      sbox[mem_i[7:0]]  <= bus.master_readdata;
            else if (mem_i < 9'd272) key[mem_i[3:0]]   <= bus.master_readdata;
            else                     block[mem_i[3:0]] <= bus.master_readdata;
        end
        if (r_state == S_KEYROUND) begin
            for (int i = 0; i < 16; i++) begin
                r_st[i] <= block[i] ^ key[i];
                r_rk[i] <= key[i];
            end
        end else if (r_state == S_ROUND) begin
            for (int i = 0; i < 16; i++) begin
                r_st[i] <= w_next_st[i];
                r_rk[i] <= w_next_rk[i];
            end
        end
    end

    // Next round key, one word at a time from the previous key words
    assign w_rcon = rcon(r_round);
    assign w_temp = {sbox[r_rk[13]] ^ w_rcon, sbox[r_rk[14]], sbox[r_rk[15]], sbox[r_rk[12]]};
    assign w_kw0  = {r_rk[0],  r_rk[1],  r_rk[2],  r_rk[3]}  ^ w_temp;
    assign w_kw1  = {r_rk[4],  r_rk[5],  r_rk[6],  r_rk[7]}  ^ w_kw0;
    assign w_kw2  = {r_rk[8],  r_rk[9],  r_rk[10], r_rk[11]} ^ w_kw1;
    assign w_kw3  = {r_rk[12], r_rk[13], r_rk[14], r_rk[15]} ^ w_kw2;

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            w_next_rk[b]      = w_kw0[31-8*b -: 8];
            w_next_rk[4 + b]  = w_kw1[31-8*b -: 8];
            w_next_rk[8 + b]  = w_kw2[31-8*b -: 8];
            w_next_rk[12 + b] = w_kw3[31-8*b -: 8];
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) w_sub[i] = sbox[r_st[i]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w_shift[r + 4*c] = w_sub[r + 4*((c + r) & 3)];
        for (int c = 0; c < 4; c++) begin
            w_mix[4*c]   = xtime(w_shift[4*c]) ^ xtime(w_shift[4*c+1]) ^ w_shift[4*c+1]
                           ^ w_shift[4*c+2] ^ w_shift[4*c+3];
            w_mix[4*c+1] = w_shift[4*c] ^ xtime(w_shift[4*c+1]) ^ xtime(w_shift[4*c+2])
                           ^ w_shift[4*c+2] ^ w_shift[4*c+3];
            w_mix[4*c+2] = w_shift[4*c] ^ w_shift[4*c+1] ^ xtime(w_shift[4*c+2])
                           ^ xtime(w_shift[4*c+3]) ^ w_shift[4*c+3];
            w_mix[4*c+3] = xtime(w_shift[4*c]) ^ w_shift[4*c] ^ w_shift[4*c+1]
                           ^ w_shift[4*c+2] ^ xtime(w_shift[4*c+3]);
        end
        for (int i = 0; i < 16; i++)
            w_next_st[i] = ((r_round == C_LAST_ROUND) ? w_shift[i] : w_mix[i]) ^ w_next_rk[i];
    end

    always_comb begin
        case (bus.slave_address)
            4'd1:                      bus.slave_readdata = {30'd0, w_busy, r_done};
            4'd2:                      bus.slave_readdata = r_word2;
            4'd4, 4'd5, 4'd6, 4'd7:    bus.slave_readdata = r_ct[bus.slave_address[1:0]];
            default:                   bus.slave_readdata = 32'd0;
        endcase
    end

    assign bus.slave_waitrequest = 1'b0;
    assign bus.master_write      = 1'b0;
    assign bus.master_writedata  = 8'd0;
    assign bus.master_read       = r_master_read;
    assign bus.master_address    = r_word2 + {23'd0, mem_i};
    assign done                  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_aes_mm_encryptor.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_mm_encryptor
// Brief    : Randomized scoreboard bench with a byte memory and AES reference.
// Revision : 1.0
// ============================================================================
module tb_aes_mm_encryptor;
    typedef logic [7:0] b16_t [16];
    typedef logic [7:0] sb_t  [256];
    typedef struct packed {
        logic [31:0]  base;
        logic [127:0] ct;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic done;
    always #5 clk = ~clk;

    aes_mm_encryptor_if bus();
    aes_mm_encryptor dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave), .done(done));

    int n_checks = 0;
    int n_pass   = 0;
    int n_seen   = 0;
    int force_stall_idx = -1;

    logic [7:0]  mem [logic [31:0]];
    logic [7:0]  img [288];
    logic [31:0] rd_log [$];
    exp_t        exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic std_sbox(output sb_t sb);
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'd0;
            for (int y = 1; y < 256 && x != 0; y++)
                if (gmul(8'(x), 8'(y)) == 8'd1) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic aes_ref(input sb_t sb, input b16_t k, input b16_t pt, output logic [127:0] ct);
        logic [31:0] w [44];
        logic [7:0]  s [4][4];
        logic [7:0]  t [4][4];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = {k[4*i], k[4*i+1], k[4*i+2], k[4*i+3]};
        for (int i = 4; i < 44; i++) begin
            logic [31:0] tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'd0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = pt[r + 4*c] ^ w[c][31-8*r -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r][c] = sb[s[r][(c + r) % 4]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = (rnd == 10) ? t[r][c] :
                              gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] ^= w[4*rnd + c][31-8*r -: 8];
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) ct[127 - 8*(4*c + r) -: 8] = s[r][c];
    endtask

    // ---------------- byte memory responder ----------------
    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    initial begin
        bit          in_req = 0;
        bit          pend = 0;
        int          stall_left = 0;
        int          lat_cnt = 0;
        int          lat;
        logic [31:0] paddr = '0;
        logic [31:0] req_addr = '0;
        bus.master_waitrequest   = 1'b0;
        bus.master_readdatavalid = 1'b0;
        bus.master_readdata      = 8'd0;
        forever begin
            @(negedge clk);
            bus.master_readdatavalid = 1'b0;
            bus.master_waitrequest   = 1'b0;
            if (!rst_n) begin
                in_req = 0;
                pend   = 0;
                continue;
            end
            if (pend) begin
                if (lat_cnt == 0) begin
                    bus.master_readdatavalid = 1'b1;
                    bus.master_readdata      = mem_rd(paddr);
                    pend = 0;
                end else lat_cnt--;
            end else if (bus.master_read) begin
                if (!in_req) begin
                    in_req     = 1;
                    req_addr   = bus.master_address;
                    stall_left = (rd_log.size() == force_stall_idx) ? 5 :
                                 (($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
                end else begin
                    check("hold_addr", bus.master_address, req_addr);
                end
                if (stall_left > 0) begin
                    bus.master_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    in_req = 0;
                    rd_log.push_back(bus.master_address);
                    lat = int'($urandom_range(0, 2));
                    if (lat == 0) begin
                        bus.master_readdatavalid = 1'b1;
                        bus.master_readdata      = mem_rd(bus.master_address);
                    end else begin
                        pend    = 1;
                        lat_cnt = lat - 1;
                        paddr   = bus.master_address;
                    end
                end
            end else if (in_req) begin
                check("hold_read", {31'd0, bus.master_read}, 32'd1);
                in_req = 0;
            end
        end
    end

    // ---------------- slave bus access ----------------
    task automatic bus_write(input logic [3:0] a, input logic [31:0] d, input int hold);
        @(negedge clk);
        bus.slave_address   = a;
        bus.slave_writedata = d;
        bus.slave_write     = 1'b1;
        repeat (hold) @(negedge clk);
        bus.slave_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        bus.slave_address = a;
        bus.slave_read    = 1'b1;
        #1;
        d = bus.slave_readdata;
        bus.slave_read    = 1'b0;
    endtask

    // ---------------- monitor ----------------
    initial begin
        bit          prev_done = 0;
        exp_t        e;
        logic [31:0] rd;
        int          bad;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 0;
                continue;
            end
            if (done && !prev_done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", {31'd0, done}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("read_count", rd_log.size(), 32'd288);
                    bad = -1;
                    for (int i = 0; i < 288; i++)
                        if (bad < 0 && (i >= rd_log.size() || rd_log[i] != e.base + 32'(i))) bad = i;
                    check("read_addr_first_bad", bad, -1);
                    bad = 0;
                    for (int i = 0; i < 256; i++) if (dut.sbox[i] !== img[i]) bad++;
                    for (int i = 0; i < 16; i++) begin
                        if (dut.key[i]   !== img[256 + i]) bad++;
                        if (dut.block[i] !== img[272 + i]) bad++;
                    end
                    check("array_bytes_bad", bad, 0);
                    bus_read(4'd1, rd); check("status_done", rd, 32'd1);
                    bus_read(4'd2, rd); check("word2", rd, e.base);
                    for (int c = 0; c < 4; c++) begin
                        bus_read(4'(4 + c), rd);
                        check($sformatf("ct%0d", c), rd, e.ct[127 - 32*c -: 32]);
                    end
                    bus_read(4'd9, rd); check("unmapped", rd, 32'd0);
                end
                n_seen++;
            end
            prev_done = done;
        end
    end

    // ---------------- stimulus ----------------
    task automatic load_image(input logic [31:0] base, input sb_t sb, input b16_t k, input b16_t pt);
        mem.delete();
        for (int i = 0; i < 256; i++) img[i] = sb[i];
        for (int i = 0; i < 16; i++) begin
            img[256 + i] = k[i];
            img[272 + i] = pt[i];
        end
        for (int i = 0; i < 288; i++) mem[base + 32'(i)] = img[i];
    endtask

    task automatic start_run(input logic [31:0] base, input int hold);
        logic [31:0] rd;
        rd_log.delete();
        bus_write(4'd2, base, 1);
        bus_write(4'd0, 32'd1, hold);
        check("done_cleared", {31'd0, done}, 32'd0);
        bus_read(4'd1, rd);
        check("status_busy", rd, 32'd2);
    endtask

    task automatic wait_result();
        int seen0 = n_seen;
        for (int cyc = 0; cyc < 8000 && n_seen == seen0; cyc++) @(negedge clk);
        check("run_completes", n_seen - seen0, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        logic [31:0] rd;
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_mread"}, {31'd0, bus.master_read}, 32'd0);
        check({tag, "_maddr"}, bus.master_address, 32'd0);
        bus_read(4'd1, rd); check({tag, "_status"}, rd, 32'd0);
        bus_read(4'd2, rd); check({tag, "_word2"}, rd, 32'd0);
        bus_read(4'd4, rd); check({tag, "_ct0"}, rd, 32'd0);
    endtask

    task automatic random_image(output sb_t sb, output b16_t k, output b16_t pt);
        for (int i = 0; i < 256; i++) sb[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            logic [7:0] t = sb[i];
            sb[i] = sb[j];
            sb[j] = t;
        end
        for (int i = 0; i < 16; i++) begin
            k[i]  = 8'($urandom);
            pt[i] = 8'($urandom);
        end
    endtask

    initial begin
        sb_t         std_sb, sb;
        b16_t        k, pt;
        logic [127:0] ct;
        logic [31:0] base;
        exp_t        e;

        rst_n = 1'b0;
        bus.slave_read = 1'b0;
        bus.slave_write = 1'b0;
        bus.slave_address = 4'd0;
        bus.slave_writedata = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        std_sbox(std_sb);
        for (int i = 0; i < 16; i++) begin
            k[i]  = 8'(i);
            pt[i] = 8'((i << 4) | i);
        end

        // Known answer at base 0: two-cycle start, ignored start mid-fetch, long stall
        load_image(32'd0, std_sb, k, pt);
        e.base = 32'd0;
        e.ct   = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
        exp_q.push_back(e);
        force_stall_idx = 10;
        start_run(32'd0, 2);
        repeat (30) @(negedge clk);
        bus_write(4'd0, 32'd1, 1);
        wait_result();

        // Same image relocated; start from DONE
        load_image(32'h1000, std_sb, k, pt);
        e.base = 32'h1000;
        exp_q.push_back(e);
        force_stall_idx = int'($urandom_range(0, 287));
        start_run(32'h1000, 1);
        wait_result();

        // Abort mid-fetch with reset, then a clean restart
        random_image(sb, k, pt);
        load_image(32'h2000, sb, k, pt);
        start_run(32'h2000, 1);
        repeat (60) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        aes_ref(sb, k, pt, ct);
        e.base = 32'h2000;
        e.ct   = ct;
        exp_q.push_back(e);
        start_run(32'h2000, 1);
        wait_result();

        // Random S-box permutations, keys, plaintexts and bases
        for (int n = 0; n < 3; n++) begin
            random_image(sb, k, pt);
            base = $urandom & 32'h00ff_fff0;
            load_image(base, sb, k, pt);
            aes_ref(sb, k, pt, ct);
            e.base = base;
            e.ct   = ct;
            exp_q.push_back(e);
            force_stall_idx = int'($urandom_range(0, 287));
            start_run(base, 1);
            wait_result();
        end

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
